// File: rtl/strip_preamble.sv
// strip_preamble: removes Ethernet preamble and SFD from an AXI-Stream byte stream.
// Define STRIP_PREAMBLE_FCS_CHECK_EN to also verify and strip the trailing 4-byte FCS.
module strip_preamble #(
    parameter int MIN_PREAMBLE_BYTES = 6
) (
    input  logic       clock,
    input  logic       aresetn,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    output logic       saxis_tready,
    input  logic       saxis_tlast,
    input  logic       saxis_tuser,
    output logic [7:0] maxis_tdata,
    output logic       maxis_tvalid,
    input  logic       maxis_tready,
    output logic       maxis_tlast,
    output logic       maxis_tuser,
    output logic       frame_dropped,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_PREAMBLE = 2'd0,
        ST_PAYLOAD  = 2'd1,
        ST_DISCARD  = 2'd2
    } state_t;

    // A threshold above 15 can never be met by the saturating 4-bit counter.
    localparam logic [4:0] MIN_L = (MIN_PREAMBLE_BYTES > 16) ? 5'd16 : 5'(MIN_PREAMBLE_BYTES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       drop_q, drop_d;
    logic [7:0] tdata_q;
    logic       tvalid_q, tlast_q, tuser_q;
    logic       in_acc;
    logic       out_load;
    logic [7:0] out_data;
    logic       out_last, out_user;
    logic       frame_err;

`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    logic [31:0] crc_q, crc_d, crc_next;
    logic [31:0] sr_q, sr_d;
    logic [2:0]  fill_q, fill_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction
`endif

    // Handshake: a beat transfers on a clock edge where tvalid && tready are both high.
    // The single output register may accept a new byte whenever it is empty or draining.
    assign saxis_tready  = !tvalid_q || maxis_tready;
    assign in_acc        = saxis_tvalid && saxis_tready;
    assign maxis_tdata   = tdata_q;
    assign maxis_tvalid  = tvalid_q;
    assign maxis_tlast   = tlast_q;
    assign maxis_tuser   = tuser_q;
    assign frame_dropped = drop_q;
    assign dbg_state_o   = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        drop_d    = 1'b0;
        out_load  = 1'b0;
        out_data  = saxis_tdata;
        out_last  = 1'b0;
        out_user  = 1'b0;
        frame_err = err_q | saxis_tuser;
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
        crc_next  = crc32_byte(crc_q, saxis_tdata);
        crc_d     = crc_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
`endif
        if (in_acc) begin
            case (state_q)
                ST_PREAMBLE: begin
                    if (saxis_tdata == 8'h55) begin
                        if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
                    end else if (saxis_tdata == 8'hD5 && {1'b0, cnt_q} >= MIN_L && !saxis_tlast) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_DISCARD;
                        cnt_d   = 4'd0;
                    end
                    if (saxis_tlast) begin
                        state_d = ST_PREAMBLE;
                        cnt_d   = 4'd0;
                        drop_d  = 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (saxis_tlast) begin
                        state_d = ST_PREAMBLE;
                        cnt_d   = 4'd0;
                        drop_d  = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    err_d = frame_err;
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
                    // Bytes emerge four beats late so the FCS never reaches the output.
                    crc_d = crc_next;
                    sr_d  = {sr_q[23:0], saxis_tdata};
                    if (fill_q == 3'd4) begin
                        out_load = 1'b1;
                        out_data = sr_q[31:24];
                        out_last = saxis_tlast;
                        out_user = saxis_tlast & (frame_err | (crc_next != CRC_RESIDUE));
                    end else begin
                        fill_d = fill_q + 3'd1;
                        drop_d = saxis_tlast;
                    end
`else
                    out_load = 1'b1;
                    out_data = saxis_tdata;
                    out_last = saxis_tlast;
                    out_user = saxis_tlast & frame_err;
`endif
                    if (saxis_tlast) begin
                        state_d = ST_PREAMBLE;
                        err_d   = 1'b0;
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
                        crc_d   = CRC_INIT;
                        fill_d  = 3'd0;
`endif
                    end
                end
                default: state_d = ST_PREAMBLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_PREAMBLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
            crc_q    <= CRC_INIT;
            sr_q     <= 32'h0;
            fill_q   <= 3'd0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            drop_q <= drop_d;
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
            crc_q  <= crc_d;
            sr_q   <= sr_d;
            fill_q <= fill_d;
`endif
            if (out_load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= out_data;
                tlast_q  <= out_last;
                tuser_q  <= out_user;
            end else if (maxis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_strip_preamble.sv
// tb_strip_preamble: table vectors, directed corner sequences and random frames
// checked against a frame-level reference model of strip_preamble.
module tb_strip_preamble;

    localparam int MIN_PRE = 6;
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
    localparam bit FCS = 1'b1;
`else
    localparam bit FCS = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] saxis_tdata = 8'h00;
    logic       saxis_tvalid = 1'b0;
    logic       saxis_tready;
    logic       saxis_tlast = 1'b0;
    logic       saxis_tuser = 1'b0;
    logic [7:0] maxis_tdata;
    logic       maxis_tvalid;
    logic       maxis_tready = 1'b1;
    logic       maxis_tlast;
    logic       maxis_tuser;
    logic       frame_dropped;
    logic [1:0] dbg_state_o;

    strip_preamble #(.MIN_PREAMBLE_BYTES(MIN_PRE)) dut (
        .clock        (clock),
        .aresetn      (aresetn),
        .saxis_tdata  (saxis_tdata),
        .saxis_tvalid (saxis_tvalid),
        .saxis_tready (saxis_tready),
        .saxis_tlast  (saxis_tlast),
        .saxis_tuser  (saxis_tuser),
        .maxis_tdata  (maxis_tdata),
        .maxis_tvalid (maxis_tvalid),
        .maxis_tready (maxis_tready),
        .maxis_tlast  (maxis_tlast),
        .maxis_tuser  (maxis_tuser),
        .frame_dropped(frame_dropped),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    int         total = 0;
    int         bad = 0;
    logic [9:0] exp_q[$];
    int         exp_drops = 0;
    int         drop_seen = 0;
    int         beats_seen = 0;
    bit         chk_en = 1'b0;
    bit         rand_ready = 1'b0;
    bit         hold_low = 1'b0;
    bit         gap_en = 1'b0;
    logic [7:0] tx_d[$];
    logic       tx_u[$];
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;
    logic [9:0] mon_e;

    typedef struct {
        int         n55;
        logic [7:0] sfd;
        int         plen;
        logic [7:0] pbase;
        int         err_idx;
        logic       exp_pass;
        logic       exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FCS value (complemented reflected CRC-32) over tx_d[from +: n]
    function automatic logic [31:0] crc_range(input int from, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = from; i < from + n; i++) begin
            c = c ^ {24'h0, tx_d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic append_fcs(input int from, input int n, input bit flip);
        logic [31:0] f;
        f = crc_range(from, n);
        if (flip) f[0] = ~f[0];
        for (int b = 0; b < 4; b++) begin
            tx_d.push_back(f[8*b +: 8]);
            tx_u.push_back(1'b0);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_frame();
        int n, i, post, k;
        bit pass;
        logic err;
        logic [31:0] rx;
        n = tx_d.size();
        i = 0;
        while (i < n && tx_d[i] == 8'h55) i++;
        pass = (i < n) && (tx_d[i] == 8'hD5) && (((i > 15) ? 15 : i) >= MIN_PRE);
        post = n - 1 - i;
        k = FCS ? post - 4 : post;
        if (pass && k > 0) begin
            err = 1'b0;
            for (int j = i + 1; j < n; j++) err = err | tx_u[j];
            if (FCS) begin
                rx = {tx_d[n-1], tx_d[n-2], tx_d[n-3], tx_d[n-4]};
                if (crc_range(i + 1, k) != rx) err = 1'b1;
            end
            for (int j = 0; j < k; j++) exp_q.push_back({j == k - 1, (j == k - 1) & err, tx_d[i+1+j]});
        end else begin
            exp_drops++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic build_vec(input vec_t v);
        tx_d.delete();
        tx_u.delete();
        for (int j = 0; j < v.n55; j++) begin tx_d.push_back(8'h55); tx_u.push_back(1'b0); end
        tx_d.push_back(v.sfd);
        tx_u.push_back(1'b0);
        for (int j = 0; j < v.plen; j++) begin
            tx_d.push_back(8'(int'(v.pbase) + j));
            tx_u.push_back(j == v.err_idx);
        end
        if (FCS) append_fcs(v.n55 + 1, v.plen, 1'b0);
    endtask

    task automatic push_vec_exp(input vec_t v);
        if (v.exp_pass) begin
            for (int j = 0; j < v.plen; j++)
                exp_q.push_back({j == v.plen - 1, (j == v.plen - 1) & v.exp_err, 8'(int'(v.pbase) + j)});
        end else begin
            exp_drops++;
        end
    endtask

    task automatic set_bytes(input logic [7:0] b[$]);
        tx_d.delete();
        tx_u.delete();
        foreach (b[i]) begin tx_d.push_back(b[i]); tx_u.push_back(1'b0); end
    endtask

    // Entered and left at posedge+1.
    task automatic send_frame(input bit end_last);
        int n, t;
        n = tx_d.size();
        for (int i = 0; i < n; i++) begin
            if (gap_en && $urandom_range(0, 3) == 0) begin
                saxis_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) begin @(posedge clock); #1; end
            end
            saxis_tvalid = 1'b1;
            saxis_tdata  = tx_d[i];
            saxis_tuser  = tx_u[i];
            saxis_tlast  = end_last && (i == n - 1);
            t = 0;
            forever begin
                @(negedge clock);
                if (saxis_tready || t >= 300) break;
                t++;
                @(posedge clock); #1;
            end
            if (!saxis_tready) begin
                check("drv_accept_timeout", 32'(t), 0);
                saxis_tvalid = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        saxis_tuser  = 1'b0;
    endtask

    task automatic settle();
        int t;
        saxis_tvalid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin @(posedge clock); t++; end
        repeat (4) @(posedge clock);
        #1;
        check("sb_empty", 32'(exp_q.size()), 0);
        check("drop_count", 32'(drop_seen), 32'(exp_drops));
    endtask

    task automatic gen_random();
        int n55, plen;
        tx_d.delete();
        tx_u.delete();
        n55 = $urandom_range(0, 10);
        for (int j = 0; j < n55; j++) begin
            tx_d.push_back(8'h55);
            tx_u.push_back($urandom_range(0, 7) == 0);
        end
        if ($urandom_range(0, 7) == 0) begin
            tx_d.push_back(8'($urandom_range(0, 255)));
            tx_u.push_back(1'b0);
            repeat ($urandom_range(0, 3)) begin tx_d.push_back(8'h55); tx_u.push_back(1'b0); end
        end
        tx_d.push_back(($urandom_range(0, 9) == 0) ? 8'hD4 : 8'hD5);
        tx_u.push_back(1'b0);
        plen = $urandom_range(0, 10);
        for (int j = 0; j < plen; j++) begin
            tx_d.push_back(8'($urandom_range(0, 255)));
            tx_u.push_back($urandom_range(0, 9) == 0);
        end
        if (FCS) append_fcs(tx_d.size() - plen, plen, $urandom_range(0, 4) == 0);
    endtask

    // ---------------- downstream ready ----------------
    initial begin
        forever begin
            @(posedge clock);
            #1;
            maxis_tready = hold_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("tready_rule", 32'(saxis_tready), 32'(!maxis_tvalid || maxis_tready));
                if (prev_stall)
                    check("hold_stable", 32'({maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tdata}), 32'({1'b1, prev_beat}));
                if (frame_dropped) drop_seen++;
                if (maxis_tvalid && maxis_tready) begin
                    beats_seen++;
                    check("beat_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        check("out_beat", 32'({maxis_tlast, maxis_tuser, maxis_tdata}), 32'(mon_e));
                    end
                end
            end
            prev_stall = chk_en && maxis_tvalid && !maxis_tready;
            prev_beat  = {maxis_tlast, maxis_tuser, maxis_tdata};
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int t, b0;
        vec_t v;
        vecs[0]  = '{7,  8'hD5, 3,  8'h01, -1, 1'b1, 1'b0};
        vecs[1]  = '{2,  8'hD5, 2,  8'hAA, -1, 1'b0, 1'b0};
        vecs[2]  = '{6,  8'hD5, 4,  8'h20, -1, 1'b1, 1'b0};
        vecs[3]  = '{5,  8'hD5, 4,  8'h30, -1, 1'b0, 1'b0};
        vecs[4]  = '{7,  8'hD5, 5,  8'h40,  1, 1'b1, 1'b1};
        vecs[5]  = '{8,  8'hD5, 0,  8'h00, -1, 1'b0, 1'b0};
        vecs[6]  = '{7,  8'hD4, 3,  8'h50, -1, 1'b0, 1'b0};
        vecs[7]  = '{15, 8'hD5, 2,  8'h60, -1, 1'b1, 1'b0};
        vecs[8]  = '{20, 8'hD5, 2,  8'h70, -1, 1'b1, 1'b0};
        vecs[9]  = '{0,  8'hD5, 1,  8'h80, -1, 1'b0, 1'b0};
        vecs[10] = '{7,  8'hD5, 1,  8'h90,  0, 1'b1, 1'b1};

        repeat (3) @(posedge clock);
        #1;
        check("rst_tvalid", 32'(maxis_tvalid), 0);
        check("rst_tdata", 32'(maxis_tdata), 0);
        check("rst_tlast", 32'(maxis_tlast), 0);
        check("rst_tuser", 32'(maxis_tuser), 0);
        check("rst_dropped", 32'(frame_dropped), 0);
        check("rst_state", 32'(dbg_state_o), 0);
        check("rst_tready", 32'(saxis_tready), 1);
        aresetn = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b1;

        // table-driven frames, back to back
        for (int i = 0; i < 11; i++) begin
            build_vec(vecs[i]);
            push_vec_exp(vecs[i]);
            send_frame(1'b1);
        end
        settle();

        // bad byte inside the preamble, then a good frame
        set_bytes('{8'h55, 8'h55, 8'h5D, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h01});
        exp_drops++;
        send_frame(1'b1);
        build_vec(vecs[0]);
        push_vec_exp(vecs[0]);
        send_frame(1'b1);
        // frame that ends while still in the preamble
        set_bytes('{8'h55, 8'h55, 8'h55});
        exp_drops++;
        send_frame(1'b1);
        settle();

        // downstream stall of 10 cycles in mid-payload
        v = '{7, 8'hD5, 20, 8'h10, -1, 1'b1, 1'b0};
        build_vec(v);
        push_vec_exp(v);
        b0 = beats_seen;
        fork
            send_frame(1'b1);
            begin
                t = 0;
                while (beats_seen < b0 + 5 && t < 500) begin @(posedge clock); t++; end
                check("stall_start", 32'(beats_seen >= b0 + 5), 1);
                @(negedge clock);
                hold_low = 1'b1;
                repeat (10) @(negedge clock);
                check("stall_tvalid", 32'(maxis_tvalid), 1);
                check("stall_sready", 32'(saxis_tready), 0);
                hold_low = 1'b0;
            end
        join
        settle();

        // reset in mid-frame: remainder of the frame must be discarded
        chk_en = 1'b0;
        set_bytes('{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h01, 8'h02});
        send_frame(1'b0);
        aresetn = 1'b0;
        #2;
        check("midrst_tvalid", 32'(maxis_tvalid), 0);
        check("midrst_tdata", 32'(maxis_tdata), 0);
        check("midrst_state", 32'(dbg_state_o), 0);
        @(posedge clock); #1;
        aresetn = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        chk_en = 1'b1;
        set_bytes('{8'h03, 8'h04, 8'h05});
        exp_drops++;
        send_frame(1'b1);
        build_vec(vecs[2]);
        push_vec_exp(vecs[2]);
        send_frame(1'b1);
        settle();

`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
        // 60 zero bytes with good FCS, then with FCS bit 0 flipped
        for (int pass = 0; pass < 2; pass++) begin
            tx_d.delete();
            tx_u.delete();
            for (int j = 0; j < 7; j++) begin tx_d.push_back(8'h55); tx_u.push_back(1'b0); end
            tx_d.push_back(8'hD5);
            tx_u.push_back(1'b0);
            for (int j = 0; j < 60; j++) begin tx_d.push_back(8'h00); tx_u.push_back(1'b0); end
            append_fcs(8, 60, pass == 1);
            for (int j = 0; j < 60; j++) exp_q.push_back({j == 59, (j == 59) && (pass == 1), 8'h00});
            send_frame(1'b1);
        end
        settle();
`endif

        // random frames with random gaps and backpressure
        rand_ready = 1'b1;
        gap_en = 1'b1;
        for (int f = 0; f < 60; f++) begin
            gen_random();
            model_frame();
            send_frame(1'b1);
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
